// File: rtl/crc_serial_enc.sv
// Bit-serial CRC encoder: accepts one DATA_W-bit word over valid/ready, divides it MSB-first
// by POLY one bit per clock, then presents the remainder and the systematic codeword.
module crc_serial_enc #(
   parameter int                 DATA_W = 8,
   parameter int                 CRC_W  = 8,
   parameter logic [CRC_W-1:0]   POLY   = 8'h07,
   parameter logic [CRC_W-1:0]   INIT   = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_clear,
   input  logic                      i_valid,
   input  logic [DATA_W-1:0]         i_data,
   output logic                      o_ready,
   output logic [CRC_W-1:0]          o_crc_code,
   output logic [DATA_W+CRC_W-1:0]   o_codeword,
   output logic                      o_crc_done
);

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   next_s;
   logic [DATA_W-1:0]        data_r;
   logic [DATA_W-1:0]        msg_r;
   logic [CRC_W-1:0]         crc_r;
   logic [CNT_W-1:0]         cnt_r;
   logic [CRC_W-1:0]         crc_nxt_s;
   logic                     accept_s;
   logic                     last_s;
   logic [CRC_W-1:0]         crc_code_r;
   logic [DATA_W+CRC_W-1:0]  codeword_r;
   logic                     done_r;

   // One LFSR division step: shift left, fold in POLY when the feedback bit is set.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                 input logic             bit_in);
      logic fb;
      fb       = crc[CRC_W-1] ^ bit_in;
      crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
   endfunction

   // Next-state decode; i_clear overrides everything, including an IDLE accept.
   always_comb begin
      next_s    = state_r;
      accept_s  = 1'b0;
      last_s    = 1'b0;
      crc_nxt_s = crc_step(crc_r, data_r[DATA_W-1]);
      if (i_clear) begin
         next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_valid) begin
                  accept_s = 1'b1;
                  next_s   = ST_SHIFT;
               end else begin
                  next_s = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == LAST_CNT) begin
                  last_s = 1'b1;
                  next_s = ST_DONE;
               end else begin
                  next_s = ST_SHIFT;
               end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Division datapath: load on accept, one message bit per SHIFT cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_r <= {DATA_W{1'b0}};
         msg_r  <= {DATA_W{1'b0}};
         crc_r  <= {CRC_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
      end else if (i_clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         data_r <= i_data;
         msg_r  <= i_data;
         crc_r  <= INIT;
         cnt_r  <= {CNT_W{1'b0}};
      end else if (state_r == ST_SHIFT) begin
         data_r <= data_r << 1;
         crc_r  <= crc_nxt_s;
         cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Result registers: captured on the final shift so they are valid throughout DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         crc_code_r <= {CRC_W{1'b0}};
         codeword_r <= {(DATA_W+CRC_W){1'b0}};
         done_r     <= 1'b0;
      end else begin
         done_r <= last_s;
         if (last_s) begin
            crc_code_r <= crc_nxt_s;
            codeword_r <= {msg_r, crc_nxt_s};
         end else begin
            crc_code_r <= crc_code_r;
         end
      end
   end

   assign o_ready    = (state_r == ST_IDLE);
   assign o_crc_code = crc_code_r;
   assign o_codeword = codeword_r;
   assign o_crc_done = done_r;

endmodule

// File: tb/tb_crc_serial_enc.sv
// Scoreboard bench for crc_serial_enc: three configurations (CRC-8 default, 3-bit/4-bit CRC,
// CRC-8 with INIT=FF); stimulus pushes hand-computed results, per-DUT monitors pop and compare.
module tb_crc_serial_enc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instance A: defaults
   logic vld_a = 1'b0, clr_a = 1'b0, rdy_a, done_a;
   logic [7:0]  dat_a = 8'h00, crc_a;
   logic [15:0] cw_a;
   // Instance B: DATA_W=3, CRC_W=4, POLY=0111
   logic vld_b = 1'b0, clr_b = 1'b0, rdy_b, done_b;
   logic [2:0]  dat_b = 3'b000;
   logic [3:0]  crc_b;
   logic [6:0]  cw_b;
   // Instance C: INIT=FF
   logic vld_c = 1'b0, clr_c = 1'b0, rdy_c, done_c;
   logic [7:0]  dat_c = 8'h00, crc_c;
   logic [15:0] cw_c;

   crc_serial_enc u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_a), .i_valid(vld_a), .i_data(dat_a),
      .o_ready(rdy_a), .o_crc_code(crc_a), .o_codeword(cw_a), .o_crc_done(done_a));

   crc_serial_enc #(.DATA_W(3), .CRC_W(4), .POLY(4'b0111), .INIT(4'b0000)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_b), .i_valid(vld_b), .i_data(dat_b),
      .o_ready(rdy_b), .o_crc_code(crc_b), .o_codeword(cw_b), .o_crc_done(done_b));

   crc_serial_enc #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'hFF)) u_dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_c), .i_valid(vld_c), .i_data(dat_c),
      .o_ready(rdy_c), .o_crc_code(crc_c), .o_codeword(cw_c), .o_crc_done(done_c));

   logic [15:0] exp_a_q[$];
   logic [6:0]  exp_b_q[$];
   logic [15:0] exp_c_q[$];
   int acc_a_q[$], acc_b_q[$], acc_c_q[$];
   int hist_a[$];

   // Monitor A
   always @(negedge clk) begin
      if (!rst_n || clr_a) begin
         acc_a_q.delete();
      end else begin
         if (vld_a && rdy_a) begin
            acc_a_q.push_back(cyc);
            hist_a.push_back(cyc);
         end
         if (done_a) begin
            if (exp_a_q.size() == 0) begin
               chk("a_unexpected_done", 1'b1, 1'b0);
            end else begin
               logic [15:0] e;
               e = exp_a_q.pop_front();
               chk("a_crc", crc_a, e[7:0]);
               chk("a_codeword", cw_a, e);
               if (acc_a_q.size() != 0) chk("a_latency", cyc - acc_a_q.pop_front(), 9);
               else chk("a_accept_seen", 1'b0, 1'b1);
            end
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (!rst_n || clr_b) begin
         acc_b_q.delete();
      end else begin
         if (vld_b && rdy_b) acc_b_q.push_back(cyc);
         if (done_b) begin
            if (exp_b_q.size() == 0) begin
               chk("b_unexpected_done", 1'b1, 1'b0);
            end else begin
               logic [6:0] e;
               e = exp_b_q.pop_front();
               chk("b_crc", crc_b, e[3:0]);
               chk("b_codeword", cw_b, e);
               if (acc_b_q.size() != 0) chk("b_latency", cyc - acc_b_q.pop_front(), 4);
               else chk("b_accept_seen", 1'b0, 1'b1);
            end
         end
      end
   end

   // Monitor C
   always @(negedge clk) begin
      if (!rst_n || clr_c) begin
         acc_c_q.delete();
      end else begin
         if (vld_c && rdy_c) acc_c_q.push_back(cyc);
         if (done_c) begin
            if (exp_c_q.size() == 0) begin
               chk("c_unexpected_done", 1'b1, 1'b0);
            end else begin
               logic [15:0] e;
               e = exp_c_q.pop_front();
               chk("c_crc", crc_c, e[7:0]);
               chk("c_codeword", cw_c, e);
               if (acc_c_q.size() != 0) chk("c_latency", cyc - acc_c_q.pop_front(), 9);
               else chk("c_accept_seen", 1'b0, 1'b1);
            end
         end
      end
   end

   task automatic send_a(input logic [7:0] d, input logic [7:0] exp_crc,
                         input bit keep, input bit push);
      bit ok = 1'b0;
      if (push) exp_a_q.push_back({d, exp_crc});
      vld_a = 1'b1;
      dat_a = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rdy_a) ok = 1'b1;
      end
      if (!ok) chk("a_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      if (!keep) vld_a = 1'b0;
   endtask

   task automatic send_b(input logic [2:0] d, input logic [3:0] exp_crc);
      bit ok = 1'b0;
      exp_b_q.push_back({d, exp_crc});
      vld_b = 1'b1;
      dat_b = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rdy_b) ok = 1'b1;
      end
      if (!ok) chk("b_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      vld_b = 1'b0;
   endtask

   task automatic send_c(input logic [7:0] d, input logic [7:0] exp_crc);
      bit ok = 1'b0;
      exp_c_q.push_back({d, exp_crc});
      vld_c = 1'b1;
      dat_c = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rdy_c) ok = 1'b1;
      end
      if (!ok) chk("c_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      vld_c = 1'b0;
   endtask

   task automatic wait_all();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         if (exp_a_q.size() == 0 && exp_b_q.size() == 0 && exp_c_q.size() == 0) ok = 1'b1;
      end
      if (!ok) chk("done_timeout", 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("reset_ready", rdy_a, 1'b1);
      chk("reset_crc", crc_a, 8'h00);
      chk("reset_codeword", cw_a, 16'h0000);
      chk("reset_done", done_a, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      send_a(8'h80, 8'h89, 1'b0, 1'b1);
      send_b(3'b101, 4'b1100);
      send_c(8'h00, 8'hF3);
      send_a(8'h01, 8'h07, 1'b0, 1'b1);
      send_b(3'b111, 4'b0010);
      send_c(8'h00, 8'hF3);
      send_a(8'h00, 8'h00, 1'b0, 1'b1);
      wait_all();

      // Back-to-back with i_valid held high
      send_a(8'h80, 8'h89, 1'b1, 1'b1);
      send_a(8'h01, 8'h07, 1'b0, 1'b1);
      wait_all();
      if (hist_a.size() >= 2) chk("b2b_spacing", hist_a[hist_a.size()-1] - hist_a[hist_a.size()-2], 10);
      else chk("b2b_accepts", 1'b0, 1'b1);

      // Abort mid-SHIFT
      send_a(8'h01, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 clr_a = 1'b1;
      @(posedge clk); #1;
      clr_a = 1'b0;
      chk("abort_ready", rdy_a, 1'b1);
      chk("abort_crc_hold", crc_a, 8'h07);
      chk("abort_done_low", done_a, 1'b0);
      repeat (20) @(posedge clk);
      #1;

      // Clear together with valid in IDLE
      vld_a = 1'b1; dat_a = 8'h80; clr_a = 1'b1;
      @(posedge clk); #1;
      chk("clear_beats_valid", rdy_a, 1'b1);
      vld_a = 1'b0; clr_a = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // Reset mid-SHIFT
      send_a(8'h80, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", rdy_a, 1'b1);
      chk("rst_mid_crc", crc_a, 8'h00);
      chk("rst_mid_codeword", cw_a, 16'h0000);
      chk("rst_mid_done", done_a, 1'b0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_a(8'h80, 8'h89, 1'b0, 1'b1);
      wait_all();

      chk("queue_a_empty", exp_a_q.size(), 0);
      chk("queue_b_empty", exp_b_q.size(), 0);
      chk("queue_c_empty", exp_c_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
